// File: rtl/serial_parity_accumulator.sv
// serial_parity_accumulator
//   Folds a stream of WIDTH-bit beats into a single parity bit per frame.
//   A frame ends on a beat flagged in_last or after FRAME_LEN beats. The
//   result is held on the output side until the consumer takes it; no new
//   beats are accepted while a result is pending.
//
// Ports
//   clk        : sole clock, rising edge
//   resetn     : synchronous active-low reset
//   in_valid   : in_data / in_last valid this cycle
//   in_ready   : block accepts a beat this cycle (IDLE or ACCUM)
//   in_data    : beat payload, WIDTH bits
//   in_last    : beat terminates the frame early
//   odd_sel    : parity mode, 0 = even, 1 = odd (sampled on first beat)
//   out_valid  : frame result available
//   out_ready  : consumer takes the result
//   out_parity : parity bit of the completed frame
//   out_beats  : beat count of the completed frame (1..FRAME_LEN)
module serial_parity_accumulator #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CW-1:0]    out_beats
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Reduction parity of one beat.
    function automatic logic beat_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN);

    state_t          state_r,  state_s;
    logic            acc_r,    acc_s;
    logic [CW-1:0]   cnt_r,    cnt_s;
    logic            mode_r,   mode_s;
    logic            valid_r,  valid_s;
    logic            parity_r, parity_s;
    logic [CW-1:0]   beats_r,  beats_s;

    logic            beat_s;
    logic            beat_par_s;
    logic            acc_sum_s;
    logic [CW-1:0]   cnt_inc_s;

    // in_ready depends only on the state register so it never loops back
    // through in_valid.
    assign in_ready   = (state_r != HOLD);
    assign out_valid  = valid_r;
    assign out_parity = parity_r;
    assign out_beats  = beats_r;

    // Beat acceptance and the values it would produce.
    always_comb begin
        beat_s     = in_valid && in_ready;
        beat_par_s = beat_parity(in_data);
        acc_sum_s  = acc_r ^ beat_par_s;
        cnt_inc_s  = cnt_r + CNT_ONE;
    end

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        mode_s   = mode_r;
        valid_s  = valid_r;
        parity_s = parity_r;
        beats_s  = beats_r;

        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    // First beat loads rather than folds, and fixes the
                    // parity mode for the whole frame.
                    acc_s  = beat_par_s;
                    cnt_s  = CNT_ONE;
                    mode_s = odd_sel;
                    if (in_last || (FRAME_LEN == 1)) begin
                        state_s  = HOLD;
                        valid_s  = 1'b1;
                        parity_s = beat_par_s ^ odd_sel;
                        beats_s  = CNT_ONE;
                    end else begin
                        state_s  = ACCUM;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            ACCUM: begin
                if (beat_s) begin
                    acc_s = acc_sum_s;
                    cnt_s = cnt_inc_s;
                    // cnt_r < FRAME_LEN here, so cnt_inc_s never passes it.
                    if (in_last || (cnt_inc_s == CNT_MAX)) begin
                        state_s  = HOLD;
                        valid_s  = 1'b1;
                        parity_s = acc_sum_s ^ mode_r;
                        beats_s  = cnt_inc_s;
                    end else begin
                        state_s  = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end

            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                    acc_s   = 1'b0;
                    cnt_s   = '0;
                end else begin
                    state_s = HOLD;
                end
            end

            default: begin
                state_s = IDLE;
                acc_s   = 1'b0;
                cnt_s   = '0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset overrides any same-cycle event.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r  <= IDLE;
            acc_r    <= 1'b0;
            cnt_r    <= '0;
            mode_r   <= 1'b0;
            valid_r  <= 1'b0;
            parity_r <= 1'b0;
            beats_r  <= '0;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            mode_r   <= mode_s;
            valid_r  <= valid_s;
            parity_r <= parity_s;
            beats_r  <= beats_s;
        end
    end

endmodule

// File: tb/tb_serial_parity_accumulator.sv
// Directed table-driven bench for serial_parity_accumulator with
// WIDTH=4, FRAME_LEN=4. Inputs change on the falling edge; outputs are
// sampled on the falling edge or just after the rising edge.
module tb_serial_parity_accumulator;

    localparam int WIDTH     = 4;
    localparam int FRAME_LEN = 4;
    localparam int CW        = 3;

    logic             clk;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_sel;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [CW-1:0]    out_beats;

    int total;
    int bad;

    serial_parity_accumulator #(
        .WIDTH(WIDTH),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .odd_sel(odd_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_parity(out_parity),
        .out_beats(out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;      // beat i in data[i*4 +: 4]
        int          n;         // beats to send
        logic        last;      // flag in_last on the final beat
        logic        odd;       // odd_sel on first beat
        logic        gaps;      // idle cycles between beats
        logic        exp_par;
        logic [2:0]  exp_beats;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Send one frame; odd_sel is inverted after the first beat and must
    // have no effect. Checks the result the cycle after the last accept.
    task automatic send_frame(input vec_t v, input int idx);
        for (int i = 0; i < v.n; i++) begin
            if (v.gaps && i > 0) begin
                @(negedge clk);
                in_valid  = 1'b0;
                in_data   = 4'(($urandom));
                in_last   = 1'b1;
                out_ready = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = v.data[i*4 +: 4];
            in_last   = (i == v.n - 1) ? v.last : 1'b0;
            odd_sel   = (i == 0) ? v.odd : ~v.odd;
            out_ready = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d in_ready_hold", idx), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d out_parity", idx), 32'(out_parity), 32'(v.exp_par));
        chk($sformatf("v%0d out_beats", idx), 32'(out_beats), 32'(v.exp_beats));
    endtask

    task automatic handshake(input int idx);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d out_valid_clr", idx), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //          data      n  last  odd   gaps  par   beats
        vecs[0] = '{16'hF731, 4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
        vecs[1] = '{16'hF731, 4, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[2] = '{16'h0001, 2, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2};
        vecs[3] = '{16'h0008, 4, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4};
        vecs[4] = '{16'h2113, 4, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
        vecs[5] = '{16'h0007, 1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[6] = '{16'h0007, 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
        vecs[7] = '{16'h0956, 3, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3};

        // Reset held 3 cycles while beats and out_ready are offered.
        resetn    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h1;
        in_last   = 1'b1;
        odd_sel   = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn    = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_parity", 32'(out_parity), 32'd0);
        chk("rst out_beats", 32'(out_beats), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                // Two beats accepted, then reset coinciding with a third beat.
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    in_valid = 1'b1;
                    in_data  = 4'h1;
                    in_last  = 1'b0;
                    odd_sel  = 1'b1;
                    @(posedge clk);
                end
                @(negedge clk);
                resetn  = 1'b0;
                in_last = 1'b1;
                @(posedge clk);
                @(negedge clk);
                resetn   = 1'b1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                chk("midrst out_valid", 32'(out_valid), 32'd0);
                chk("midrst in_ready", 32'(in_ready), 32'd1);
                chk("midrst out_beats", 32'(out_beats), 32'd0);
                @(posedge clk);
                @(negedge clk);
                chk("midrst idle out_valid", 32'(out_valid), 32'd0);
            end

            send_frame(vecs[k], k);

            if (k == 0) begin
                // Result pending: outputs stable, beats refused, for 5 cycles.
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    in_valid  = 1'b1;
                    in_data   = 4'h1;
                    in_last   = 1'b1;
                    out_ready = 1'b0;
                    @(posedge clk);
                    #1;
                    chk($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
                    chk($sformatf("hold%0d out_parity", c), 32'(out_parity), 32'd0);
                    chk($sformatf("hold%0d out_beats", c), 32'(out_beats), 32'd4);
                    chk($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
                end
                in_last = 1'b0;
            end

            if (k == 6) begin
                // Reset while a result is pending discards it.
                @(negedge clk);
                resetn    = 1'b0;
                out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                resetn    = 1'b1;
                out_ready = 1'b0;
                chk("holdrst out_valid", 32'(out_valid), 32'd0);
                chk("holdrst in_ready", 32'(in_ready), 32'd1);
                chk("holdrst out_parity", 32'(out_parity), 32'd0);
            end else begin
                handshake(k);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
